fft_spectrum_buf: RTL and testbench

FFT_SPECTRUM_BUF -- requirements
Module: fft_spectrum_buf

---
 rtl/fft_spectrum_buf.sv | 163 ++++++++++++++++
 tb/tb_fft_spectrum_buf.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_spectrum_buf.sv
// Double-buffered FFT magnitude store: captures one frame of bins into the write bank
// while the display reads the other bank; banks swap on a vsync rising edge once a frame is full.
module fft_spectrum_buf #(
  parameter int FFT_POINT   = 256,
  parameter int SCALE_SHIFT = 0
) (
  input  logic        pix_clk,
  input  logic        rst,
  input  logic [15:0] fft_re,
  input  logic [15:0] fft_im,
  input  logic        fft_valid,
  input  logic        fft_last,
  output logic        fft_ready,
  input  logic        vs_in,
  input  logic        data_req,
  input  logic [9:0]  RAM_address,
  output logic [31:0] fft_data,
  output logic        frame_done,
  output logic        err,
  output logic [1:0]  dbg_state_o
);

  localparam int IW = (FFT_POINT > 1) ? $clog2(FFT_POINT) : 1;
  localparam int AW = $clog2(2 * FFT_POINT);
  localparam logic [IW-1:0] LAST_IDX = IW'(FFT_POINT - 1);

  typedef enum logic [1:0] {
    ST_CAPTURE = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_FULL    = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic          vs_q, vs_rise, swap, accept;
  logic [IW-1:0] idx_q;
  logic          drain_q;
  logic          wr_bank_q, bank_valid_q;
  logic          frame_done_q, err_q;
  logic [31:0]   fft_data_q;

  logic          s1_v_q;
  logic [16:0]   s1_re_q, s1_im_q;
  logic [IW-1:0] s1_idx_q;
  logic          s2_v_q;
  logic [15:0]   s2_mag_q;
  logic [IW-1:0] s2_idx_q;

  logic [16:0]   mag_max, mag_min, mag_sum;
  logic [AW-1:0] wr_addr, rd_addr;
  logic          rd_in_range;

  logic [15:0] mem_q [0:2*FFT_POINT-1];

  function automatic logic [16:0] abs16(input logic [15:0] v);
    logic [16:0] ext;
    ext = {v[15], v};
    return v[15] ? (~ext + 17'd1) : ext;
  endfunction

  // Handshake: a bin transfers on any cycle where fft_valid and fft_ready are both 1;
  // fft_ready depends only on state and rst, never on fft_valid.
  assign accept  = fft_valid & fft_ready;
  assign vs_rise = vs_in & ~vs_q;
  assign swap    = (state_q == ST_FULL) & vs_rise;

  always_ff @(posedge pix_clk) begin
    if (rst) state_q <= ST_CAPTURE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CAPTURE: if (accept && idx_q == LAST_IDX) state_d = ST_DRAIN;
      ST_DRAIN:   if (drain_q) state_d = ST_FULL;
      ST_FULL:    if (vs_rise) state_d = ST_CAPTURE;
      default:    state_d = ST_CAPTURE;
    endcase
  end

  always_comb begin
    fft_ready   = (state_q == ST_CAPTURE) & ~rst;
    dbg_state_o = state_q;
  end

  always_ff @(posedge pix_clk) begin
    if (rst) begin
      vs_q         <= 1'b0;
      idx_q        <= '0;
      drain_q      <= 1'b0;
      wr_bank_q    <= 1'b0;
      bank_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      vs_q         <= vs_in;
      frame_done_q <= swap;
      drain_q      <= (state_q == ST_DRAIN) ? ~drain_q : 1'b0;
      if (accept) begin
        if (idx_q == LAST_IDX) begin
          idx_q <= '0;
          if (!fft_last) err_q <= 1'b1;
        end else if (fft_last) begin
          // Short frame: drop it and start over from bin 0.
          idx_q <= '0;
          err_q <= 1'b1;
        end else begin
          idx_q <= idx_q + IW'(1);
        end
      end
      if (swap) begin
        wr_bank_q    <= ~wr_bank_q;
        bank_valid_q <= 1'b1;
        idx_q        <= '0;
      end
    end
  end

  always_comb begin
    mag_max = (s1_re_q >= s1_im_q) ? s1_re_q : s1_im_q;
    mag_min = (s1_re_q >= s1_im_q) ? s1_im_q : s1_re_q;
    mag_sum = mag_max + {1'b0, mag_min[16:1]};
  end

  always_ff @(posedge pix_clk) begin
    if (rst) begin
      s1_v_q <= 1'b0;
      s2_v_q <= 1'b0;
    end else begin
      s1_v_q <= accept;
      s2_v_q <= s1_v_q;
    end
    s1_re_q  <= abs16(fft_re);
    s1_im_q  <= abs16(fft_im);
    s1_idx_q <= idx_q;
    s2_mag_q <= mag_sum[15:0];
    s2_idx_q <= s1_idx_q;
  end

  // The write bank is stable while the pipeline holds data; swaps only happen in FULL.
  assign wr_addr     = AW'(s2_idx_q) + (wr_bank_q ? AW'(FFT_POINT) : AW'(0));
  assign rd_addr     = AW'(RAM_address) + (wr_bank_q ? AW'(0) : AW'(FFT_POINT));
  assign rd_in_range = ({22'd0, RAM_address} < 32'(FFT_POINT));

  always_ff @(posedge pix_clk) begin
    if (s2_v_q) mem_q[wr_addr] <= s2_mag_q;
  end

  always_ff @(posedge pix_clk) begin
    if (rst) begin
      fft_data_q <= '0;
    end else if (data_req) begin
      fft_data_q <= (bank_valid_q && rd_in_range) ?
                    ({16'd0, mem_q[rd_addr]} << SCALE_SHIFT) : 32'd0;
    end
  end

  assign fft_data   = fft_data_q;
  assign frame_done = frame_done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_fft_spectrum_buf.sv
// Randomized bench for fft_spectrum_buf: two instances (shift 0 and shift 4) share stimulus
// and are checked against a frame-level model of capture, swap and readout.
module tb_fft_spectrum_buf;

  localparam int N = 256;
  localparam logic [1:0] S_CAP   = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;

  logic        pix_clk = 1'b0;
  logic        rst;
  logic [15:0] fft_re, fft_im;
  logic        fft_valid, fft_last, vs_in, data_req;
  logic [9:0]  RAM_address;
  logic        rdy0, rdy4, fd0, fd4, err0, err4;
  logic [31:0] d0, d4;
  logic [1:0]  st0, st4;

  int checks   = 0;
  int failures = 0;

  int m_cur  [N];
  int m_disp [N];
  int m_idx;
  bit m_full, m_bv, m_err;

  fft_spectrum_buf #(.FFT_POINT(N), .SCALE_SHIFT(0)) dut (
    .pix_clk(pix_clk), .rst(rst), .fft_re(fft_re), .fft_im(fft_im),
    .fft_valid(fft_valid), .fft_last(fft_last), .fft_ready(rdy0), .vs_in(vs_in),
    .data_req(data_req), .RAM_address(RAM_address), .fft_data(d0),
    .frame_done(fd0), .err(err0), .dbg_state_o(st0)
  );

  fft_spectrum_buf #(.FFT_POINT(N), .SCALE_SHIFT(4)) dut4 (
    .pix_clk(pix_clk), .rst(rst), .fft_re(fft_re), .fft_im(fft_im),
    .fft_valid(fft_valid), .fft_last(fft_last), .fft_ready(rdy4), .vs_in(vs_in),
    .data_req(data_req), .RAM_address(RAM_address), .fft_data(d4),
    .frame_done(fd4), .err(err4), .dbg_state_o(st4)
  );

  always #5 pix_clk = ~pix_clk;

  task automatic tick;
    @(posedge pix_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int mag_of(input int re, input int im);
    int a, b, hi, lo;
    a  = (re < 0) ? -re : re;
    b  = (im < 0) ? -im : im;
    hi = (a > b) ? a : b;
    lo = (a > b) ? b : a;
    return hi + lo / 2;
  endfunction

  function automatic int rnd_s16();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  task automatic model_accept(input int re, input int im, input bit last);
    if (m_idx == N - 1) begin
      m_cur[m_idx] = mag_of(re, im);
      if (!last) m_err = 1'b1;
      m_full = 1'b1;
      m_idx  = 0;
    end else if (last) begin
      m_err = 1'b1;
      m_idx = 0;
    end else begin
      m_cur[m_idx] = mag_of(re, im);
      m_idx++;
    end
  endtask

  task automatic push_bin(input int re, input int im, input bit last, input bit vs);
    int n;
    repeat ($urandom_range(0, 2)) begin
      fft_valid = 1'b0;
      fft_re    = 16'($urandom);
      fft_im    = 16'($urandom);
      fft_last  = 1'($urandom);
      tick();
    end
    fft_re    = 16'(re);
    fft_im    = 16'(im);
    fft_last  = last;
    fft_valid = 1'b1;
    vs_in     = vs;
    n = 0;
    while (!rdy0 && n < 20) begin
      tick();
      n++;
    end
    check("ready_in_capture", {31'd0, rdy0}, 32'd1);
    tick();
    fft_valid = 1'b0;
    fft_last  = 1'b0;
    vs_in     = 1'b0;
    model_accept(re, im, last);
  endtask

  task automatic check_drain;
    check("drain_cycle1", {30'd0, st0}, {30'd0, S_DRAIN});
    check("drain1_ready", {31'd0, rdy0}, 32'd0);
    check("drain1_fd", {31'd0, fd0}, 32'd0);
    tick();
    check("drain_cycle2", {30'd0, st0}, {30'd0, S_DRAIN});
    check("drain2_fd", {31'd0, fd0}, 32'd0);
    tick();
    check("full_state", {30'd0, st0}, {30'd0, S_FULL});
    check("full_state_s4", {30'd0, st4}, {30'd0, S_FULL});
    check("full_ready", {31'd0, rdy0}, 32'd0);
    check("full_ready_s4", {31'd0, rdy4}, 32'd0);
    tick();
    check("full_holds", {30'd0, st0}, {30'd0, S_FULL});
    check("full_fd", {31'd0, fd0}, 32'd0);
  endtask

  task automatic swap_pulse;
    bit exp_fd;
    exp_fd = m_full;
    vs_in  = 1'b1;
    tick();
    check("frame_done_pulse", {31'd0, fd0}, {31'd0, exp_fd});
    check("frame_done_pulse_s4", {31'd0, fd4}, {31'd0, exp_fd});
    if (exp_fd) begin
      for (int i = 0; i < N; i++) m_disp[i] = m_cur[i];
      m_bv   = 1'b1;
      m_full = 1'b0;
      m_idx  = 0;
      check("state_after_swap", {30'd0, st0}, {30'd0, S_CAP});
    end
    tick();
    check("frame_done_one_cycle", {31'd0, fd0}, 32'd0);
    vs_in = 1'b0;
    tick();
  endtask

  task automatic read_check(input int a);
    int e;
    data_req    = 1'b1;
    RAM_address = 10'(a);
    tick();
    data_req = 1'b0;
    e = (m_bv && a < N) ? m_disp[a] : 0;
    check($sformatf("read_a%0d", a), d0, 32'(e));
    check($sformatf("read_s4_a%0d", a), d4, 32'(e) << 4);
    RAM_address = 10'($urandom_range(0, 1023));
    tick();
    check($sformatf("hold_a%0d", a), d0, 32'(e));
  endtask

  task automatic check_err(input string tag);
    check(tag, {31'd0, err0}, {31'd0, m_err});
    check({tag, "_s4"}, {31'd0, err4}, {31'd0, m_err});
  endtask

  task automatic random_frame(input bit last_ok, input bit vs_on_last);
    for (int k = 0; k < N; k++)
      push_bin(rnd_s16(), rnd_s16(), (k == N - 1) && last_ok, (k == N - 1) && vs_on_last);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog_timeout got=%0d exp=%0d", checks, 0);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; fft_re = '0; fft_im = '0; fft_valid = 1'b0; fft_last = 1'b0;
    vs_in = 1'b0; data_req = 1'b0; RAM_address = '0;
    m_idx = 0; m_full = 1'b0; m_bv = 1'b0; m_err = 1'b0;
    repeat (3) tick();
    check("rst_ready_low", {31'd0, rdy0}, 32'd0);
    check("rst_data", d0, 32'd0);
    check("rst_frame_done", {31'd0, fd0}, 32'd0);
    check("rst_err", {31'd0, err0}, 32'd0);
    check("rst_state", {30'd0, st0}, {30'd0, S_CAP});
    rst = 1'b0;
    #1;
    check("ready_after_rst", {31'd0, rdy0}, 32'd1);
    read_check(5);

    // Frame A: fixed pattern with extreme bins
    for (int k = 0; k < N; k++) begin
      int re, im;
      re = 3000; im = 4000;
      if (k == 7) begin re = 3;      im = 4;      end
      if (k == 8) begin re = -32768; im = -32768; end
      if (k == 9) begin re = 0;      im = 0;      end
      push_bin(re, im, k == N - 1, 1'b0);
    end
    check_err("err_clean_frame");
    check_drain();
    read_check(5);
    swap_pulse();
    read_check(7);
    read_check(8);
    read_check(9);
    read_check(0);
    read_check(N - 1);
    read_check(N);
    read_check(300);

    // Frame B: ignored vsync mid-frame, short frame, then a full frame with vsync on its last bin
    for (int k = 0; k < 30; k++) push_bin(rnd_s16(), rnd_s16(), 1'b0, 1'b0);
    swap_pulse();
    check("no_swap_in_capture", {30'd0, st0}, {30'd0, S_CAP});
    read_check(7);
    for (int k = 30; k < 100; k++) push_bin(rnd_s16(), rnd_s16(), 1'b0, 1'b0);
    push_bin(rnd_s16(), rnd_s16(), 1'b1, 1'b0);
    check_err("err_short_frame");
    random_frame(1'b1, 1'b1);
    check_drain();
    read_check(7);
    swap_pulse();
    for (int i = 0; i < 6; i++) read_check($urandom_range(0, N - 1));

    // Reset in the middle of a frame
    for (int k = 0; k < 50; k++) push_bin(rnd_s16(), rnd_s16(), 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    check("midrst_ready_low", {31'd0, rdy0}, 32'd0);
    rst = 1'b0;
    m_idx = 0; m_full = 1'b0; m_bv = 1'b0; m_err = 1'b0;
    #1;
    check("midrst_data", d0, 32'd0);
    check("midrst_ready", {31'd0, rdy0}, 32'd1);
    check_err("midrst_err");
    read_check($urandom_range(0, N - 1));

    // Frame D: missing fft_last on the final bin
    for (int k = 0; k < N - 1; k++) push_bin(rnd_s16(), rnd_s16(), 1'b0, 1'b0);
    check_err("err_before_last");
    push_bin(rnd_s16(), rnd_s16(), 1'b0, 1'b0);
    check_err("err_missing_last");
    check_drain();
    swap_pulse();
    for (int i = 0; i < 6; i++) read_check($urandom_range(0, N - 1));
    read_check(N - 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
